demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Sequential controller that owns the select lines of the team's gate-level 1-to-4 demultiplexer and shares the single input stream among four downstream consumers. It buffers one beat and presents it to one channel at a time. Channels are visited round-robin in bursts. A channel that stalls too long loses its turn.

## Interface
Parameters:
- `W`, 8, data width.
- `BURST`, 4, max beats per channel turn; legal range 1..16.
- `TIMEOUT`, 15, stall cycles before a turn is forfeited; legal range 1..255.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `chan_mask`  in  4  channel enable; bit n = channel n eligible.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  W  upstream beat.
- `in_ready`  out  1  controller accepts beat this cycle.
- `out_valid`  out  4  one-hot; bit `sel` = held beat offered to that channel.
- `out_data`  out  W  held beat, shared by all channels.
- `out_ready`  in  4  per-channel accept.
- `sel`  out  2  current channel; `sel[1]` drives demux s2, `sel[0]` drives s1.

## Operation
- State:
  - `hold_valid`/`hold_data`: one-entry output register.
  - `sel`: channel pointer.
  - `beat_cnt`: 0..BURST-1.
  - `stall_cnt`: 0..TIMEOUT.
- FSM states:
  - EMPTY (`hold_valid`=0).
  - OFFER (`hold_valid`=1).
- Output and handshake signals:
  - `out_valid` = `hold_valid` ? (1<<`sel`) : 0.
  - xfer = `hold_valid` & `out_ready[sel]` & `chan_mask[sel]`.
  - `in_ready` = (`chan_mask` != 0) & (!`hold_valid` | xfer); forced 0 while `rst` is asserted.
  - accept = `in_valid` & `in_ready`; loads `hold_data`, `hold_valid`=1.
- Transitions:
  - EMPTY→OFFER on accept.
  - OFFER→EMPTY on xfer without accept.
  - OFFER→OFFER on xfer with accept (back-to-back, 1 beat/cycle).
- next_chan(`sel`, `chan_mask`): first of `sel`+1, +2, +3, +0 (mod 4) whose mask bit is set. If the mask is 0, returns `sel` unchanged.
- On xfer:
  - `stall_cnt`←0.
  - If `beat_cnt`==BURST-1: `beat_cnt`←0 and `sel`←next_chan.
  - Otherwise: `beat_cnt`++.
- On OFFER without xfer:
  - If `chan_mask[sel]`==0: advance `sel`←next_chan, `beat_cnt`←0, `stall_cnt`←0 (forfeit immediately).
  - Else if `stall_cnt`==TIMEOUT-1: forfeit the same way.
  - Otherwise: `stall_cnt`++.
  - In every case `hold_data` is retained and re-offered on the new `sel`.
- In EMPTY, `sel` moves only if `chan_mask[sel]`==0 (advance to next_chan). `beat_cnt` is kept.
- Data is never dropped or duplicated. Each held beat goes to exactly one channel.

## Timing
- Reset values:
  - `hold_valid`=0, `hold_data`=0, `out_data`=0, `out_valid`=0.
  - `sel`=0, `beat_cnt`=0, `stall_cnt`=0, `in_ready`=0.
- Latency: beat accepted at edge k is offered (`out_valid`) in cycle k+1. Minimum 1 cycle in to out.
- Throughput: 1 beat/cycle when the selected channel is continuously ready.
- `sel` changes only at a clock edge. It is stable throughout any cycle in which `out_valid` is nonzero. `sel` and `out_valid` change in the same edge.
- Forfeit happens after TIMEOUT consecutive non-xfer OFFER cycles. The new channel is offered in the next cycle.
- Simultaneous xfer on the last burst beat and accept: the new beat is offered on next_chan in the following cycle.
- `chan_mask` all zero: no accepts; a held beat stays in OFFER with no forfeits until a bit is set.
- `rst` mid-transfer: the held beat is discarded. Outputs reach reset values immediately (asynchronously).

## Structure
- Package `demux_pkg`:
  - `NCH`=4, `SEL_W`=2.
  - `typedef` `chan_t` (2-bit).
  - `typedef` `ctrl_state_e` {EMPTY, OFFER}.
- Sub-module `rr_next_chan`: combinational rotate-priority search (`sel`, `mask` → next `sel`). It is instantiated once.
- Counters and FSM live in `demux_dispatch_ctrl`.

## Test plan
- Reset, mask=4'b1111, all `out_ready`=1, 12 beats 0x01..0x0C back-to-back → channel 0 gets 01–04, ch1 05–08, ch2 09–0C; `sel` reaches 3; `in_ready` stays 1 from the cycle after reset.
- mask=4'b0101, ready=all, 8 beats → ch0 gets 4, ch2 gets 4, then `sel`=0; ch1/ch3 `out_valid` never set.
- mask=4'b1111, `out_ready[0]`=0, one beat 0xAA, TIMEOUT=15 → offered on ch0 for 15 cycles, then on ch1 in cycle 16 and delivered there; `in_ready`=0 during the stall.
- Offer 0x55 on ch2, clear `chan_mask[2]` mid-stall → next cycle `sel`=3, 0x55 delivered on ch3 exactly once.
- Assert `rst` while `hold_valid`=1 → same cycle: `out_valid`=0, `in_ready`=0; after release `sel`=0, first new beat goes to ch0.
- mask=4'b0000 with `in_valid`=1 for 20 cycles → `in_ready`=0 throughout, `out_valid`=0; set mask=4'b1000 → beat accepted and delivered on ch3.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the demux dispatch controller
package demux_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] chan_t;

  typedef enum logic {
    EMPTY,
    OFFER
  } ctrl_state_e;
endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// rtl/demux_dispatch_ctrl_if.sv - upstream beat, per-channel offer and demux select bundle
interface demux_dispatch_ctrl_if #(parameter int W = 8) ();
  import demux_pkg::*;

  logic [NCH-1:0] chan_mask;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [NCH-1:0] out_valid;
  logic [W-1:0]   out_data;
  logic [NCH-1:0] out_ready;
  chan_t          sel;

  modport slave (
    input  chan_mask, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel
  );

  modport master (
    output chan_mask, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/rr_next_chan.sv
// rtl/rr_next_chan.sv - rotate-priority search for the next enabled channel after cur
module rr_next_chan
  import demux_pkg::*;
(
  input  chan_t          cur,
  input  logic [NCH-1:0] mask,
  output chan_t          nxt
);

  // Scan from farthest (+4 == cur) to nearest so the closest enabled channel wins.
  always_comb begin
    nxt = cur;
    for (int i = NCH; i >= 1; i--) begin
      if (mask[cur + chan_t'(i)]) nxt = cur + chan_t'(i);
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - one-beat holding register dispatched round-robin in bursts
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int W       = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  demux_dispatch_ctrl_if.slave bus
);

  localparam logic [3:0]     BEAT_LAST  = 4'(BURST - 1);
  localparam logic [7:0]     STALL_LAST = 8'(TIMEOUT - 1);
  localparam logic [NCH-1:0] CH0_BIT    = {{(NCH-1){1'b0}}, 1'b1};

  ctrl_state_e  state, state_nxt;
  logic [W-1:0] hold_data, hold_data_nxt;
  chan_t        sel_q, sel_nxt, adv_chan;
  logic [3:0]   beat_cnt, beat_nxt;
  logic [7:0]   stall_cnt, stall_nxt;
  logic         hold_valid, xfer, accept, in_ready_int;

  rr_next_chan u_next (
    .cur  (sel_q),
    .mask (bus.chan_mask),
    .nxt  (adv_chan)
  );

  assign hold_valid   = (state == OFFER);
  assign xfer         = hold_valid & bus.out_ready[sel_q] & bus.chan_mask[sel_q];
  assign in_ready_int = !rst & (bus.chan_mask != '0) & (!hold_valid | xfer);
  assign accept       = bus.in_valid & in_ready_int;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = hold_valid ? (CH0_BIT << sel_q) : '0;
  assign bus.out_data  = hold_data;
  assign bus.sel       = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      hold_data <= '0;
      sel_q     <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      hold_data <= hold_data_nxt;
      sel_q     <= sel_nxt;
      beat_cnt  <= beat_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_data_nxt = hold_data;
    sel_nxt       = sel_q;
    beat_nxt      = beat_cnt;
    stall_nxt     = stall_cnt;

    if (accept) hold_data_nxt = bus.in_data;

    case (state)
      EMPTY: begin
        if (accept) state_nxt = OFFER;
        if (!bus.chan_mask[sel_q]) sel_nxt = adv_chan;
      end
      OFFER: begin
        if (xfer) begin
          stall_nxt = '0;
          if (beat_cnt == BEAT_LAST) begin
            beat_nxt = '0;
            sel_nxt  = adv_chan;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
          if (!accept) state_nxt = EMPTY;
        end else if (!bus.chan_mask[sel_q] || stall_cnt == STALL_LAST) begin
          // Forfeit: the held beat moves to the next eligible channel untouched.
          sel_nxt   = adv_chan;
          beat_nxt  = '0;
          stall_nxt = '0;
        end else begin
          stall_nxt = stall_cnt + 8'd1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - scoreboard bench for the demux dispatch controller
module tb_demux_dispatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_dispatch_ctrl_if #(.W(8)) bus ();

  demux_dispatch_ctrl #(.W(8), .BURST(4), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_waits = 0;
  int bad_valid = 0;
  bit phase2 = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (phase2 && (bus.out_valid[1] || bus.out_valid[3])) bad_valid++;
      for (int c = 0; c < 4; c++) begin
        if (bus.out_valid[c] && bus.out_ready[c] && bus.chan_mask[c]) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("chan", 32'(c), 32'(mon_e[9:8]));
            check("data", 32'(bus.out_data), 32'(mon_e[7:0]));
            check("sel_match", 32'(bus.sel), 32'(c));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.chan_mask = 4'b1111;
    bus.out_ready = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int ch, input bit expect_out);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    if (expect_out) exp_q.push_back({2'(ch), d});
    #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    stall_waits += n;
    check("accept_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.chan_mask = 4'b1111;
    bus.out_ready = 4'b1111;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);

    // Full mask, bursts of four across channels 0..2.
    do_reset();
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    stall_waits = 0;
    for (int i = 1; i <= 12; i++) send(8'(i), (i - 1) / 4, 1'b1);
    drain("drain_t1");
    check("t1_no_stall", 32'(stall_waits), 32'd0);
    check("t1_sel", 32'(bus.sel), 32'd3);

    // Sparse mask: only channels 0 and 2 receive.
    do_reset();
    bus.chan_mask = 4'b0101;
    phase2 = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), (i < 4) ? 0 : 2, 1'b1);
    drain("drain_t2");
    phase2 = 1'b0;
    check("t2_bad_valid", 32'(bad_valid), 32'd0);
    check("t2_sel", 32'(bus.sel), 32'd0);

    // Stall timeout on channel 0 forfeits to channel 1.
    do_reset();
    bus.out_ready = 4'b1110;
    send(8'hAA, 1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      check("t3_offer_ch0", 32'(bus.out_valid), 32'h1);
      check("t3_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("t3_offer_ch1", 32'(bus.out_valid), 32'h2);
    drain("drain_t3");

    // Mask cleared under a stalled offer on channel 2.
    do_reset();
    bus.chan_mask = 4'b0100;
    bus.out_ready = 4'b0000;
    @(posedge clk);
    #1;
    check("t4_sel_pre", 32'(bus.sel), 32'd2);
    bus.chan_mask = 4'b1111;
    send(8'h55, 3, 1'b1);
    @(posedge clk);
    #1;
    check("t4_offer_ch2", 32'(bus.out_valid), 32'h4);
    bus.chan_mask = 4'b1011;
    @(posedge clk);
    #1;
    check("t4_sel", 32'(bus.sel), 32'd3);
    check("t4_offer_ch3", 32'(bus.out_valid), 32'h8);
    bus.out_ready = 4'b1000;
    drain("drain_t4");
    repeat (3) @(posedge clk);
    #1;

    // Reset while a beat is held discards it.
    do_reset();
    bus.out_ready = 4'b0000;
    send(8'h77, 0, 1'b0);
    check("t5_held", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(bus.out_valid), 32'd0);
    check("t5_async_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("t5_sel", 32'(bus.sel), 32'd0);
    bus.out_ready = 4'b1111;
    send(8'h31, 0, 1'b1);
    drain("drain_t5");

    // No channel enabled: nothing accepted until a mask bit appears.
    do_reset();
    bus.chan_mask = 4'b0000;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t6_in_ready", 32'(bus.in_ready), 32'd0);
      check("t6_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
    end
    #1;
    bus.chan_mask = 4'b1000;
    send(8'h99, 3, 1'b1);
    drain("drain_t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
